// File: rtl/temporizador_rr.sv
// rtl/temporizador_rr.sv - preemptive quantum timer injecting a 5-word context-switch trap sequence
module temporizador_rr #(
  parameter int unsigned QUANTUM_PADRAO = 80,
  parameter int unsigned NUM_CTX        = 4,
  parameter int unsigned MODO           = 0,
  parameter int unsigned END_SO         = 201,
  parameter int unsigned REG_PC         = 29,
  parameter int unsigned REG_BR         = 28,
  parameter int unsigned REG_CTX        = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] contexto,
  input  logic        habilita,
  input  logic        cfg_we,
  input  logic [15:0] cfg_quantum,
  output logic [31:0] saida_instrucao,
  output logic        flag_pausa,
  output logic [31:0] prox_contexto,
  output logic [15:0] trocas
);

  localparam logic [31:0] NOP       = {6'b101000, 26'd0};
  localparam logic [31:0] END_SO_W  = 32'(END_SO);
  localparam logic [31:0] REG_PC_W  = 32'(REG_PC);
  localparam logic [31:0] REG_BR_W  = 32'(REG_BR);
  localparam logic [31:0] REG_CTX_W = 32'(REG_CTX);
  localparam logic [31:0] ULT_CTX   = 32'(NUM_CTX - 1);
  localparam logic [15:0] Q_RESET   = 16'(QUANTUM_PADRAO);

  typedef enum logic {CONTANDO, INJETANDO} estado_t;

  estado_t     state_q;
  logic [15:0] contador_q;
  logic [15:0] quantum_q;
  logic [2:0]  indice_q;
  logic [31:0] ctx_prev_q;
  logic [31:0] prox_contexto_q;
  logic [15:0] trocas_q;
  logic        flag_pausa_q;
  logic [31:0] saida_q;

  logic [16:0] contador_inc_d;
  logic [31:0] prox_ctx_d;
  logic [2:0]  indice_d;
  logic [31:0] palavra_d;

  assign contador_inc_d = {1'b0, contador_q} + 17'd1;
  assign indice_d       = indice_q + 3'd1;

  // Context that will run after this preemption: OS, or the next user context in rotation
  always_comb begin
    prox_ctx_d = 32'd0;
    if (MODO != 0) begin
      if (contexto < ULT_CTX) prox_ctx_d = contexto + 32'd1;
      else                    prox_ctx_d = 32'd1;
    end
  end

  // Trap word presented on the cycle after indice_q advances
  always_comb begin
    palavra_d = NOP;
    case (indice_d)
      3'd1:    palavra_d = {6'b000110, REG_PC_W[4:0], 21'd0};
      3'd2:    palavra_d = {6'b000001, REG_BR_W[4:0], END_SO_W[20:0]};
      3'd3:    palavra_d = {6'b000001, REG_CTX_W[4:0], prox_contexto_q[20:0]};
      3'd4:    palavra_d = {6'b111111, REG_BR_W[4:0], REG_CTX_W[4:0], 16'd0};
      default: palavra_d = NOP;
    endcase
  end

  // Counting / injection FSM with registered outputs; quantum writes are accepted in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= CONTANDO;
      contador_q      <= 16'd0;
      quantum_q       <= Q_RESET;
      indice_q        <= 3'd0;
      ctx_prev_q      <= 32'd0;
      prox_contexto_q <= 32'd0;
      trocas_q        <= 16'd0;
      flag_pausa_q    <= 1'b0;
      saida_q         <= NOP;
    end else begin
      ctx_prev_q <= contexto;
      if (cfg_we) quantum_q <= cfg_quantum;
      case (state_q)
        CONTANDO: begin
          flag_pausa_q <= 1'b0;
          saida_q      <= NOP;
          if (contexto == 32'd0 || contexto != ctx_prev_q) begin
            contador_q <= 16'd0;
          end else if (habilita && quantum_q != 16'd0) begin
            // Compare against the quantum held before any write on this same edge
            if (contador_inc_d >= {1'b0, quantum_q}) begin
              state_q         <= INJETANDO;
              indice_q        <= 3'd0;
              contador_q      <= 16'd0;
              prox_contexto_q <= prox_ctx_d;
              trocas_q        <= trocas_q + 16'd1;
              flag_pausa_q    <= 1'b1;
              saida_q         <= NOP;
            end else begin
              contador_q <= contador_inc_d[15:0];
            end
          end
        end
        INJETANDO: begin
          if (indice_q == 3'd4) begin
            state_q      <= CONTANDO;
            indice_q     <= 3'd0;
            flag_pausa_q <= 1'b0;
            saida_q      <= NOP;
          end else begin
            indice_q <= indice_d;
            saida_q  <= palavra_d;
          end
        end
        default: state_q <= CONTANDO;
      endcase
    end
  end

  assign saida_instrucao = saida_q;
  assign flag_pausa      = flag_pausa_q;
  assign prox_contexto   = prox_contexto_q;
  assign trocas          = trocas_q;

endmodule

// File: tb/tb_temporizador_rr.sv
// tb/tb_temporizador_rr.sv - directed bench for temporizador_rr in OS-return and round-robin modes
module tb_temporizador_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] contexto;
  logic        habilita;
  logic        cfg_we;
  logic [15:0] cfg_quantum;

  logic [31:0] saida_os, prox_os, saida_rr, prox_rr;
  logic        flag_os, flag_rr;
  logic [15:0] trocas_os, trocas_rr;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'hA0000000;

  always #5 clk = ~clk;

  temporizador_rr #(.MODO(0)) dut (
    .clk(clk), .rst(rst), .contexto(contexto), .habilita(habilita),
    .cfg_we(cfg_we), .cfg_quantum(cfg_quantum),
    .saida_instrucao(saida_os), .flag_pausa(flag_os),
    .prox_contexto(prox_os), .trocas(trocas_os)
  );

  temporizador_rr #(.MODO(1), .NUM_CTX(4)) dut_rr (
    .clk(clk), .rst(rst), .contexto(contexto), .habilita(habilita),
    .cfg_we(cfg_we), .cfg_quantum(cfg_quantum),
    .saida_instrucao(saida_rr), .flag_pausa(flag_rr),
    .prox_contexto(prox_rr), .trocas(trocas_rr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; contexto = 32'd0; habilita = 1'b0; cfg_we = 1'b0; cfg_quantum = 16'd0;
    step(2);
    rst = 1'b0;
    chk("rst_flag", 32'(flag_os), 32'd0);
    chk("rst_saida", saida_os, NOP);
    chk("rst_prox", prox_os, 32'd0);
    chk("rst_trocas", 32'(trocas_os), 32'd0);

    // 1: quantum 10, context 2, OS mode
    cfg_quantum = 16'd10; cfg_we = 1'b1;
    step(1);
    cfg_we = 1'b0; contexto = 32'd2; habilita = 1'b1;
    step(1);
    step(9);
    chk("t1_no_flag_9", 32'(flag_os), 32'd0);
    step(1);
    chk("t1_flag_10", 32'(flag_os), 32'd1);
    chk("t1_w0", saida_os, NOP);
    step(1); chk("t1_w1", saida_os, 32'h1BA00000);
    step(1); chk("t1_w2", saida_os, 32'h078000C9);
    step(1); chk("t1_w3", saida_os, 32'h07C00000);
    step(1); chk("t1_w4", saida_os, 32'hFF9E0000);
    chk("t1_flag_w4", 32'(flag_os), 32'd1);
    step(1);
    chk("t1_flag_drop", 32'(flag_os), 32'd0);
    chk("t1_nop_after", saida_os, NOP);
    chk("t1_trocas", 32'(trocas_os), 32'd1);
    chk("t1_rr_prox", prox_rr, 32'd3);

    // 2: quantum 5, round-robin wrap and advance
    cfg_quantum = 16'd5; cfg_we = 1'b1; contexto = 32'd3;
    step(1);
    cfg_we = 1'b0;
    step(5);
    chk("t2_rr_flag", 32'(flag_rr), 32'd1);
    step(3);
    chk("t2_rr_w3", saida_rr, 32'h07C00001);
    chk("t2_os_w3", saida_os, 32'h07C00000);
    chk("t2_rr_prox3", prox_rr, 32'd1);
    step(2);
    chk("t2_rr_back", 32'(flag_rr), 32'd0);
    contexto = 32'd1;
    step(6);
    chk("t2_rr_flag1", 32'(flag_rr), 32'd1);
    chk("t2_rr_prox1", prox_rr, 32'd2);
    chk("t2_rr_trocas", 32'(trocas_rr), 32'd3);
    step(5);

    // 3: OS context never counts; habilita pause holds the count
    contexto = 32'd0;
    step(200);
    chk("t3_os_no_flag", 32'(flag_os), 32'd0);
    chk("t3_trocas", 32'(trocas_os), 32'd3);
    cfg_quantum = 16'd8; cfg_we = 1'b1; contexto = 32'd1;
    step(1);
    cfg_we = 1'b0;
    step(4);
    habilita = 1'b0;
    step(20);
    chk("t3_paused", 32'(flag_os), 32'd0);
    habilita = 1'b1;
    step(3);
    chk("t3_resume_3", 32'(flag_os), 32'd0);
    step(1);
    chk("t3_resume_4", 32'(flag_os), 32'd1);
    step(5);

    // 4: context switch restarts count; quantum 0 disables preemption
    cfg_quantum = 16'd10; cfg_we = 1'b1; contexto = 32'd0;
    step(1);
    cfg_we = 1'b0; contexto = 32'd1;
    step(1);
    step(7);
    contexto = 32'd2;
    step(1);
    step(9);
    chk("t4_restart_9", 32'(flag_os), 32'd0);
    step(1);
    chk("t4_restart_10", 32'(flag_os), 32'd1);
    step(5);
    chk("t4_trocas", 32'(trocas_os), 32'd5);
    cfg_quantum = 16'd0; cfg_we = 1'b1;
    step(1);
    cfg_we = 1'b0;
    step(50);
    chk("t4_q0_no_flag", 32'(flag_os), 32'd0);

    // 5: reset in the middle of injection
    cfg_quantum = 16'd5; cfg_we = 1'b1; contexto = 32'd3;
    step(1);
    cfg_we = 1'b0;
    step(5);
    chk("t5_flag", 32'(flag_os), 32'd1);
    step(2);
    chk("t5_w2", saida_os, 32'h078000C9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_rst_flag", 32'(flag_os), 32'd0);
    chk("t5_rst_saida", saida_os, NOP);
    chk("t5_rst_trocas", 32'(trocas_os), 32'd0);
    chk("t5_rst_prox", prox_rr, 32'd0);
    step(1);
    step(79);
    chk("t5_q80_79", 32'(flag_os), 32'd0);
    step(1);
    chk("t5_q80_80", 32'(flag_os), 32'd1);
    step(5);

    // 6: lowering the quantum below the count, then trocas wrap
    contexto = 32'd0;
    step(1);
    contexto = 32'd3;
    step(1);
    step(6);
    cfg_quantum = 16'd3; cfg_we = 1'b1;
    step(1);
    cfg_we = 1'b0;
    chk("t6_old_q_edge", 32'(flag_os), 32'd0);
    step(1);
    chk("t6_lower_q", 32'(flag_os), 32'd1);
    chk("t6_trocas", 32'(trocas_os), 32'd2);
    step(5);
    habilita = 1'b0;
    force dut.trocas_q = 16'hFFFF;
    step(1);
    release dut.trocas_q;
    chk("t6_forced", 32'(trocas_os), 32'h0000FFFF);
    habilita = 1'b1;
    step(3);
    chk("t6_wrap_flag", 32'(flag_os), 32'd1);
    chk("t6_wrap", 32'(trocas_os), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
